// File: rtl/lap_stash.sv
// Lap-sample circular buffer: captures BCD time on Sample edges, steps display on Next edges.
// Optional build macro LAP_STASH_OVERWRITE_EN: a write while full replaces the oldest entry.
module lap_stash #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           sample_in,
  input  logic                       sample_in_valid,
  input  logic                       next_sample,
  output logic [WIDTH-1:0]           sample_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [$clog2(DEPTH)-1:0]   sel_index,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  localparam int CW  = $clog2(DEPTH+1);
  localparam int PW  = $clog2(DEPTH);
  localparam int PW1 = PW + 1;

  // Reduce a sum of two in-range pointers back into 0..DEPTH-1.
  function automatic logic [PW-1:0] ptr_wrap(input logic [PW:0] s);
    logic [PW:0] r;
    if (s >= PW1'(DEPTH)) begin
      r = s - PW1'(DEPTH);
    end else begin
      r = s;
    end
    return r[PW-1:0];
  endfunction

  logic             sample_prev_r;
  logic             next_prev_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic [PW-1:0]    rd_idx_r;
  logic             overflow_r;
  logic             full_r;
  logic             empty_r;
  logic [WIDTH-1:0] sample_out_r;

  logic             sample_pulse_s;
  logic             next_pulse_s;
  logic             mem_we_s;
  logic [PW-1:0]    wr_ptr_nx_s;
  logic [CW-1:0]    count_nx_s;
  logic [PW-1:0]    rd_idx_nx_s;
  logic             overflow_nx_s;
  logic [PW-1:0]    oldest_s;
  logic [PW-1:0]    rd_phys_s;

  assign sample_pulse_s = sample_in_valid & ~sample_prev_r;
  assign next_pulse_s   = next_sample & ~next_prev_r;
  assign oldest_s  = ptr_wrap({1'b0, wr_ptr_r} + (PW1'(DEPTH) - PW1'(count_r)));
  assign rd_phys_s = ptr_wrap({1'b0, oldest_s} + {1'b0, rd_idx_r});

  // Next-state: a write always wins over a simultaneous Next request.
  always_comb begin
    mem_we_s      = 1'b0;
    wr_ptr_nx_s   = wr_ptr_r;
    count_nx_s    = count_r;
    rd_idx_nx_s   = rd_idx_r;
    overflow_nx_s = overflow_r;
    if (sample_pulse_s) begin
      if (count_r < CW'(DEPTH)) begin
        mem_we_s    = 1'b1;
        wr_ptr_nx_s = ptr_wrap({1'b0, wr_ptr_r} + PW1'(1));
        count_nx_s  = count_r + CW'(1);
        rd_idx_nx_s = PW'(count_r);
      end else begin
        overflow_nx_s = 1'b1;
`ifdef LAP_STASH_OVERWRITE_EN
        mem_we_s    = 1'b1;
        wr_ptr_nx_s = ptr_wrap({1'b0, wr_ptr_r} + PW1'(1));
        rd_idx_nx_s = PW'(DEPTH - 1);
`else
        mem_we_s    = 1'b0;
`endif
      end
    end else if (next_pulse_s && (count_r != CW'(0))) begin
      if (CW'(rd_idx_r) == (count_r - CW'(1))) begin
        rd_idx_nx_s = PW'(0);
      end else begin
        rd_idx_nx_s = rd_idx_r + PW'(1);
      end
    end else begin
      rd_idx_nx_s = rd_idx_r;
    end
  end

  // State and registered outputs; reset preloads edge detectors with the live level.
  always_ff @(posedge clk) begin
    sample_prev_r <= sample_in_valid;
    next_prev_r   <= next_sample;
    if (reset) begin
      wr_ptr_r     <= PW'(0);
      count_r      <= CW'(0);
      rd_idx_r     <= PW'(0);
      overflow_r   <= 1'b0;
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
      sample_out_r <= WIDTH'(0);
    end else begin
      wr_ptr_r     <= wr_ptr_nx_s;
      count_r      <= count_nx_s;
      rd_idx_r     <= rd_idx_nx_s;
      overflow_r   <= overflow_nx_s;
      full_r       <= (count_nx_s == CW'(DEPTH));
      empty_r      <= (count_nx_s == CW'(0));
      sample_out_r <= (count_r != CW'(0)) ? mem_r[rd_phys_s] : WIDTH'(0);
    end
  end

  // Sample storage; contents are masked by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      mem_r[wr_ptr_r] <= sample_in;
    end
  end

  assign sample_out = sample_out_r;
  assign count      = count_r;
  assign sel_index  = rd_idx_r;
  assign full       = full_r;
  assign empty      = empty_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_lap_stash.sv
// Directed self-checking bench for lap_stash (DEPTH=5, WIDTH=8).
module tb_lap_stash;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sample_in;
  logic       sample_in_valid;
  logic       next_sample;
  logic [7:0] sample_out;
  logic [2:0] count;
  logic [2:0] sel_index;
  logic       full;
  logic       empty;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  lap_stash #(.DEPTH(5), .WIDTH(8)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in),
    .sample_in_valid(sample_in_valid), .next_sample(next_sample),
    .sample_out(sample_out), .count(count), .sel_index(sel_index),
    .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_sample(input logic [7:0] d);
    sample_in = d;
    sample_in_valid = 1'b1;
    tick();
    sample_in_valid = 1'b0;
    tick();
  endtask

  task automatic pulse_next();
    next_sample = 1'b1;
    tick();
    next_sample = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (sample_out !== 8'h00) begin n_bad++; $display("FAIL reset_sample_out got=%h exp=00", sample_out); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_cmp++; if (sel_index !== 3'd0) begin n_bad++; $display("FAIL reset_sel got=%0d exp=0", sel_index); end
    n_cmp++; if ({full, empty, overflow} !== 3'b010) begin n_bad++; $display("FAIL reset_flags got=%b exp=010", {full, empty, overflow}); end
  endtask

  task automatic test_sample();
    pulse_sample(8'h12);
    pulse_sample(8'h34);
    // Latency: count moves on edge k, sample_out only on edge k+1.
    sample_in = 8'h56;
    sample_in_valid = 1'b1;
    tick();
    sample_in_valid = 1'b0;
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL lat_count got=%0d exp=3", count); end
    n_cmp++; if (sample_out !== 8'h34) begin n_bad++; $display("FAIL lat_old_out got=%h exp=34", sample_out); end
    tick();
    n_cmp++; if (sample_out !== 8'h56) begin n_bad++; $display("FAIL sample_out got=%h exp=56", sample_out); end
    n_cmp++; if (sel_index !== 3'd2) begin n_bad++; $display("FAIL sample_sel got=%0d exp=2", sel_index); end
    n_cmp++; if ({full, empty} !== 2'b00) begin n_bad++; $display("FAIL sample_flags got=%b exp=00", {full, empty}); end
  endtask

  task automatic test_next();
    logic [7:0] exp_d [4];
    logic [2:0] exp_s [4];
    exp_d = '{8'h12, 8'h34, 8'h56, 8'h12};
    exp_s = '{3'd0, 3'd1, 3'd2, 3'd0};
    for (int i = 0; i < 4; i++) begin
      pulse_next();
      n_cmp++; if (sample_out !== exp_d[i]) begin n_bad++; $display("FAIL next_out[%0d] got=%h exp=%h", i, sample_out, exp_d[i]); end
      n_cmp++; if (sel_index !== exp_s[i]) begin n_bad++; $display("FAIL next_sel[%0d] got=%0d exp=%0d", i, sel_index, exp_s[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_d [5];
    do_reset();
    for (int i = 1; i <= 5; i++) pulse_sample(8'(i));
    n_cmp++; if ({full, overflow, count} !== {1'b1, 1'b0, 3'd5}) begin n_bad++; $display("FAIL fill_state got=%b%b/%0d exp=10/5", full, overflow, count); end
    pulse_sample(8'h06);
    n_cmp++; if ({full, overflow, count} !== {1'b1, 1'b1, 3'd5}) begin n_bad++; $display("FAIL ovf_state got=%b%b/%0d exp=11/5", full, overflow, count); end
    n_cmp++; if (sel_index !== 3'd4) begin n_bad++; $display("FAIL ovf_sel got=%0d exp=4", sel_index); end
`ifdef LAP_STASH_OVERWRITE_EN
    n_cmp++; if (sample_out !== 8'h06) begin n_bad++; $display("FAIL ovf_out got=%h exp=06", sample_out); end
    exp_d = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
`else
    n_cmp++; if (sample_out !== 8'h05) begin n_bad++; $display("FAIL ovf_out got=%h exp=05", sample_out); end
    exp_d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
`endif
    for (int i = 0; i < 5; i++) begin
      pulse_next();
      n_cmp++; if (sample_out !== exp_d[i]) begin n_bad++; $display("FAIL ovf_step[%0d] got=%h exp=%h", i, sample_out, exp_d[i]); end
    end
  endtask

  task automatic test_hold_and_both();
    do_reset();
    sample_in = 8'h42;
    sample_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    sample_in_valid = 1'b0;
    tick();
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL hold_count got=%0d exp=1", count); end
    n_cmp++; if (sample_out !== 8'h42) begin n_bad++; $display("FAIL hold_out got=%h exp=42", sample_out); end
    pulse_sample(8'h07);
    pulse_next();
    n_cmp++; if (sel_index !== 3'd0) begin n_bad++; $display("FAIL pre_both_sel got=%0d exp=0", sel_index); end
    sample_in = 8'h99;
    sample_in_valid = 1'b1;
    next_sample = 1'b1;
    tick();
    sample_in_valid = 1'b0;
    next_sample = 1'b0;
    tick();
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL both_count got=%0d exp=3", count); end
    n_cmp++; if (sel_index !== 3'd2) begin n_bad++; $display("FAIL both_sel got=%0d exp=2", sel_index); end
    n_cmp++; if (sample_out !== 8'h99) begin n_bad++; $display("FAIL both_out got=%h exp=99", sample_out); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    sample_in = 8'h21;
    sample_in_valid = 1'b1; tick();
    sample_in_valid = 1'b0; tick();
    sample_in = 8'h22;
    sample_in_valid = 1'b1; tick();
    sample_in_valid = 1'b0; tick();
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL b2b_count got=%0d exp=2", count); end
    n_cmp++; if (sample_out !== 8'h22) begin n_bad++; $display("FAIL b2b_out got=%h exp=22", sample_out); end
    next_sample = 1'b1; tick();
    next_sample = 1'b0; tick();
    next_sample = 1'b1; tick();
    next_sample = 1'b0; tick();
    n_cmp++; if (sel_index !== 3'd1) begin n_bad++; $display("FAIL b2b_next_sel got=%0d exp=1", sel_index); end
  endtask

  task automatic test_reset_held();
    for (int i = 1; i <= 6; i++) pulse_sample(8'(i));
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL pre_rst_ovf got=%b exp=1", overflow); end
    next_sample = 1'b1;
    sample_in_valid = 1'b1;
    reset = 1'b1;
    tick();
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rst_prio_count got=%0d exp=0", count); end
    reset = 1'b0;
    tick();
    tick();
    n_cmp++; if ({count, sel_index} !== {3'd0, 3'd0}) begin n_bad++; $display("FAIL rst_held_cnt_sel got=%0d/%0d exp=0/0", count, sel_index); end
    n_cmp++; if ({sample_out, empty, overflow} !== {8'h00, 1'b1, 1'b0}) begin n_bad++; $display("FAIL rst_held_out got=%h/%b%b exp=00/10", sample_out, empty, overflow); end
    next_sample = 1'b0;
    sample_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_next_empty();
    do_reset();
    pulse_next();
    n_cmp++; if ({sample_out, sel_index, count} !== {8'h00, 3'd0, 3'd0}) begin n_bad++; $display("FAIL empty_next got=%h/%0d/%0d exp=00/0/0", sample_out, sel_index, count); end
    n_cmp++; if ({full, empty, overflow} !== 3'b010) begin n_bad++; $display("FAIL empty_flags got=%b exp=010", {full, empty, overflow}); end
  endtask

  initial begin
    reset = 1'b1;
    sample_in = 8'h00;
    sample_in_valid = 1'b0;
    next_sample = 1'b0;
    test_reset();
    test_sample();
    test_next();
    test_overflow();
    test_hold_and_both();
    test_back_to_back();
    test_reset_held();
    test_next_empty();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lap_stash.md
# lap_stash

Lap-sample storage stage for the stopwatch datapath: sits directly downstream of the BCD time counter and the button debouncers, and directly upstream of the 7-segment display driver. It captures the live 8-bit BCD time into a small circular buffer on a Sample request and presents one stored sample for display. A Next request steps the displayed sample through the stored entries in age order, wrapping around.

## Interface
- `DEPTH`, 5, number of stored samples (2..16)
- `WIDTH`, 8, sample width in bits (two BCD digits)
- `clk` in 1 — system clock (100 MHz)
- `reset` in 1 — synchronous, active-high; clears all state
- `sample_in` in WIDTH — live time reading from the counter
- `sample_in_valid` in 1 — debounced Sample button level; the rising edge is the request
- `next_sample` in 1 — debounced Next button level; the rising edge is the request
- `sample_out` out WIDTH — selected stored sample; 0 when empty
- `count` out $clog2(DEPTH+1) — number of valid entries
- `sel_index` out $clog2(DEPTH) — logical index of the displayed entry (0 = oldest)
- `full` out 1 — count == DEPTH
- `empty` out 1 — count == 0
- `overflow` out 1 — sticky; set when a write arrives while full

## Operation
- Edge detect: per-input `prev` registers; `pulse = in & ~prev`. While `reset` is high, `prev` loads the current input level, so a button held through reset does not create a request.
- Storage: `mem[0..DEPTH-1]`, write pointer `wr_ptr`, `count`, and logical read index `rd_idx`. Oldest physical slot = (`wr_ptr` − `count`) mod DEPTH.
- Write (sample pulse, count < DEPTH): `mem[wr_ptr] <= sample_in`; `wr_ptr` advances mod DEPTH; `count`++; `rd_idx <= count` (the new entry becomes the displayed one).
- Write while full:
  - `overflow <= 1` in all builds.
  - Further behaviour is set by the macro (see Configuration).
- Next (next pulse, count > 0): `rd_idx <= (rd_idx == count-1) ? 0 : rd_idx+1`.
- Next while empty: no effect.
- Both pulses in the same cycle: the write is performed and the next pulse is discarded.
- `sample_out` is registered: `mem[(oldest + rd_idx) mod DEPTH]` when count > 0, otherwise 0.
- `full`, `empty`, `count`, and `sel_index` are driven directly from state registers.
- All pointer arithmetic is mod DEPTH and must be correct for non-power-of-two DEPTH. No BCD arithmetic is performed; data passes through unchanged.

## Timing
- Reset values: `sample_out`=0, `count`=0, `sel_index`=0, `full`=0, `empty`=1, `overflow`=0, `wr_ptr`=0. Memory contents are don't-care; they are masked by `count`.
- The input is first sampled high at edge k. Pointers, count, and memory update at edge k. `sample_out` reflects the change at edge k+1, giving 2-edge latency from the input to `sample_out`.
- A level held high produces exactly one request. A new request requires the input to be low for at least one sampled cycle.
- Back-to-back requests on alternating cycles (1,0,1) are each honoured.
- `reset` asserted mid-operation takes priority over every pulse in that cycle. The next cycle shows the reset values.

## Configuration
- `LAP_STASH_OVERWRITE_EN` defined:
  - A write while full overwrites the oldest entry. `wr_ptr` advances, `count` stays DEPTH, and `rd_idx <= DEPTH-1` (newest).
  - `overflow` is still set.
- Undefined (default):
  - A write while full is dropped. Memory, pointers, and `rd_idx` are unchanged.
  - Only `overflow` is set.

## Test plan
- Reset, then sample 0x12, 0x34, 0x56 -> `count`=3; `sample_out`=0x56 two edges after the last request; `sel_index`=2; `empty`=0.
- From that state, pulse next four times -> `sample_out` sequence 0x12, 0x34, 0x56, 0x12 (wraps at `count`).
- Fill 5 entries 0x01..0x05, then sample 0x06:
  - Without the macro: `overflow`=1, `full`=1, `sample_out`=0x05, and stepping shows 0x01..0x05.
  - With the macro: `sample_out`=0x06, and stepping shows 0x02..0x06.
- Hold `sample_in_valid` high for 10 cycles with `sample_in`=0x42 -> `count` increments by exactly 1. Both pulses in the same cycle -> the write occurs and `sel_index` goes to the newest entry, not the next one.
- Hold `next_sample` high through a reset pulse; release reset while it is still high -> no step; `sample_out`=0, `empty`=1, `overflow`=0.
- Next pulse while empty -> all outputs unchanged (`sample_out`=0, `sel_index`=0).
